// File: rtl/filtro_iir_banda.sv
// Biquad IIR section for one equalizer band.
// One shared multiplier walks the five taps over five clocks per sample.
module filtro_iir_banda #(
    parameter int N   = 23,
    parameter int Dec = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic signed [N-1:0] x_in,
    input  logic signed [N-1:0] b0,
    input  logic signed [N-1:0] b1,
    input  logic signed [N-1:0] b2,
    input  logic signed [N-1:0] a1,
    input  logic signed [N-1:0] a2,
    output logic signed [N-1:0] y_out,
    output logic                done,
    output logic                busy
);

    localparam int AW = 2 * N + 3;

    localparam logic signed [AW-1:0] MAXV =
        {{(AW - N + 1){1'b0}}, {(N - 1){1'b1}}};
    localparam logic signed [AW-1:0] MINV =
        {{(AW - N + 1){1'b1}}, {(N - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        SAT
    } state_t;

    state_t state;

    logic signed [N-1:0]    xr;
    logic signed [N-1:0]    x1;
    logic signed [N-1:0]    x2;
    logic signed [N-1:0]    y1;
    logic signed [N-1:0]    y2;
    logic signed [AW-1:0]   acc;
    logic [2:0]             k;

    logic signed [N-1:0]    cm;
    logic signed [N-1:0]    dm;
    logic                   sub;
    logic signed [2*N-1:0]  prod;
    logic signed [AW-1:0]   pext;
    logic signed [AW-1:0]   sh;
    logic signed [N-1:0]    r;

    // Tap selection: feedback terms are subtracted.
    always_comb begin
        cm  = '0;
        dm  = '0;
        sub = 1'b0;
        unique case (k)
            3'd0: begin cm = b0; dm = xr; end
            3'd1: begin cm = b1; dm = x1; end
            3'd2: begin cm = b2; dm = x2; end
            3'd3: begin cm = a1; dm = y1; sub = 1'b1; end
            3'd4: begin cm = a2; dm = y2; sub = 1'b1; end
            default: ;
        endcase
    end

    assign prod = cm * dm;
    assign pext = {{3{prod[2*N-1]}}, prod};

    always_comb begin
        sh = acc >>> Dec;
        if (sh > MAXV)
            r = MAXV[N-1:0];
        else if (sh < MINV)
            r = MINV[N-1:0];
        else
            r = sh[N-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            xr    <= '0;
            x1    <= '0;
            x2    <= '0;
            y1    <= '0;
            y2    <= '0;
            acc   <= '0;
            k     <= '0;
            y_out <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        xr    <= x_in;
                        acc   <= '0;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= sub ? acc - pext : acc + pext;
                    k   <= k + 3'd1;
                    if (k == 3'd4)
                        state <= SAT;
                end
                SAT: begin
                    y_out <= r;
                    done  <= 1'b1;
                    x2    <= x1;
                    x1    <= xr;
                    y2    <= y1;
                    y1    <= r;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_filtro_iir_banda.sv
// Bench for filtro_iir_banda: directed vector table, corner
// sequences and a random run against an arithmetic reference.
module tb_filtro_iir_banda;

    localparam int N = 23;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic signed [N-1:0] x_in;
    logic signed [N-1:0] b0, b1, b2, a1, a2;
    logic signed [N-1:0] y_out;
    logic                done;
    logic                busy;

    int checks = 0;
    int errors = 0;

    filtro_iir_banda #(.N(N), .Dec(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .x_in  (x_in),
        .b0    (b0),
        .b1    (b1),
        .b2    (b2),
        .a1    (a1),
        .a2    (a2),
        .y_out (y_out),
        .done  (done),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst_first;
        int c0, c1, c2, d1, d2;
        int x;
        int y;
    } vec_t;

    vec_t tbl[13];

    // reference model state
    int  rb0, rb1, rb2, ra1, ra2;
    longint mx1, mx2, my1, my2;

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_coef(input int c0, input int c1, input int c2,
                            input int d1, input int d2);
        @(negedge clk);
        b0 = c0; b1 = c1; b2 = c2; a1 = d1; a2 = d2;
        rb0 = c0; rb1 = c1; rb2 = c2; ra1 = d1; ra2 = d2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("reset y_out", y_out, 0);
        chk("reset done", done, 0);
        chk("reset busy", busy, 0);
        reset = 1'b0;
        mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
    endtask

    // Returns the filtered sample and the number of edges after E0.
    task automatic run_sample(input int x, output int y, output int lat);
        @(negedge clk);
        x_in  = x;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        y = y_out;
    endtask

    function automatic longint model_step(input longint x);
        longint s, q;
        s = rb0 * x + rb1 * mx1 + rb2 * mx2 - ra1 * my1 - ra2 * my2;
        q = s / 256;
        if ((s % 256 != 0) && s < 0)
            q = q - 1;
        if (q > 4194303)
            q = 4194303;
        if (q < -4194304)
            q = -4194304;
        mx2 = mx1;
        mx1 = x;
        my2 = my1;
        my1 = q;
        return q;
    endfunction

    initial begin
        int y, lat, n, ndone;

        tbl[0]  = '{1, 256, 0, 0, 0, 0, 1000, 1000};
        tbl[1]  = '{0, 256, 0, 0, 0, 0, -1000, -1000};
        tbl[2]  = '{1, 0, 256, 0, 0, 0, 5, 0};
        tbl[3]  = '{0, 0, 256, 0, 0, 0, 7, 5};
        tbl[4]  = '{0, 0, 256, 0, 0, 0, 9, 7};
        tbl[5]  = '{1, 256, 0, 0, -128, 0, 512, 512};
        tbl[6]  = '{0, 256, 0, 0, -128, 0, 0, 256};
        tbl[7]  = '{0, 256, 0, 0, -128, 0, 0, 128};
        tbl[8]  = '{0, 256, 0, 0, -128, 0, 0, 64};
        tbl[9]  = '{1, 1024, 0, 0, 0, 0, 2097152, 4194303};
        tbl[10] = '{0, 1024, 0, 0, 0, 0, -2097152, -4194304};
        tbl[11] = '{0, 128, 0, 0, 0, 0, -3, -2};
        tbl[12] = '{1, 256, 256, 256, 0, 0, 1, 1};

        reset = 1'b1;
        start = 1'b0;
        x_in = '0;
        b0 = '0; b1 = '0; b2 = '0; a1 = '0; a2 = '0;
        #12;
        chk("async reset y_out", y_out, 0);
        chk("async reset busy", busy, 0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            if (tbl[i].rst_first)
                do_reset();
            set_coef(tbl[i].c0, tbl[i].c1, tbl[i].c2,
                     tbl[i].d1, tbl[i].d2);
            run_sample(tbl[i].x, y, lat);
            chk($sformatf("vec%0d y", i), y, tbl[i].y);
            chk($sformatf("vec%0d latency", i), lat, 6);
        end

        // second start at E3 must be dropped
        do_reset();
        set_coef(256, 0, 0, 0, 0);
        @(negedge clk);
        x_in = 100;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy after accept", busy, 1);
        n = 0;
        ndone = 0;
        lat = -1;
        while (n < 20) begin
            if (n == 2) begin
                x_in = 999;
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
            if (n == 3)
                start = 1'b0;
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = n;
                    y = y_out;
                end
            end
        end
        chk("ignored start dones", ndone, 1);
        chk("ignored start latency", lat, 6);
        chk("ignored start y", y, 100);
        set_coef(0, 256, 0, 0, 0);
        run_sample(0, y, lat);
        chk("delay holds first sample", y, 100);

        // start during done cycle
        set_coef(256, 0, 0, 0, 0);
        run_sample(11, y, lat);
        chk("b2b first y", y, 11);
        x_in = 22;
        start = 1'b1;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            start = 1'b0;
            if (done)
                break;
        end
        chk("b2b spacing", n, 7);
        chk("b2b second y", y_out, 22);

        // reset in the middle of a computation
        do_reset();
        set_coef(256, 256, 256, -256, -256);
        run_sample(300, y, lat);
        run_sample(400, y, lat);
        @(negedge clk);
        x_in = 77;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midop y_out", y_out, 0);
        chk("midop busy", busy, 0);
        ndone = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done)
                ndone++;
        end
        chk("midop no done", ndone, 0);
        @(negedge clk);
        reset = 1'b0;
        mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
        run_sample(50, y, lat);
        chk("after midop reset y", y, 50);
        chk("after midop reset lat", lat, 6);

        // random coefficients and samples against the model
        for (int g = 0; g < 4; g++) begin
            do_reset();
            set_coef($urandom_range(0, 600) - 300,
                     $urandom_range(0, 600) - 300,
                     $urandom_range(0, 600) - 300,
                     $urandom_range(0, 400) - 200,
                     $urandom_range(0, 200) - 100);
            for (int s = 0; s < 12; s++) begin
                int xv;
                longint ye;
                if ($urandom_range(0, 3) == 0)
                    xv = $urandom_range(0, 8388607) - 4194304;
                else
                    xv = $urandom_range(0, 10000) - 5000;
                ye = model_step(xv);
                run_sample(xv, y, lat);
                chk($sformatf("rand g%0d s%0d y", g, s), y, ye);
                chk($sformatf("rand g%0d s%0d lat", g, s), lat, 6);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
